// File: rtl/program_sequencer_if.sv
// rtl/program_sequencer_if.sv - ROM and control-unit signal bundle for the program sequencer
interface program_sequencer_if #(parameter int N = 2);
    logic         run;
    logic [7:0]   instruction;
    logic         zed;
    logic [N-1:0] addr;
    logic [7:0]   instr_q;
    logic         exec_en;
    logic         halted;
    logic         busy;

    modport master (
        input  run, instruction, zed,
        output addr, instr_q, exec_en, halted, busy
    );

    modport slave (
        output run, instruction, zed,
        input  addr, instr_q, exec_en, halted, busy
    );
endinterface

// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - Fetch/execute sequencer resolving JMP/SKZ/HLT and strobing data-path opcodes
module program_sequencer #(
    parameter int N = 2
) (
    input logic                 clk,
    input logic                 rst,
    program_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [3:0] OP_HLT = 4'hD;
    localparam logic [3:0] OP_SKZ = 4'hE;
    localparam logic [3:0] OP_JMP = 4'hF;

    state_t       state;
    state_t       state_nxt;
    logic [N-1:0] addr_q;
    logic [N-1:0] addr_nxt;
    logic [N-1:0] addr_plus1;
    logic [N-1:0] addr_plus2;
    logic [7:0]   instr_r;
    logic [3:0]   opcode;
    logic         is_ctrl;

    assign opcode     = instr_r[7:4];
    assign is_ctrl    = (opcode == OP_HLT) || (opcode == OP_SKZ) || (opcode == OP_JMP);
    // Chained increments keep the modulo-2^N wrap correct for every legal N, including N=1.
    assign addr_plus1 = addr_q + N'(1);
    assign addr_plus2 = addr_plus1 + N'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_q;
        case (state)
            IDLE: begin
                if (bus.run) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                state_nxt = bus.run ? EXEC : IDLE;
            end
            EXEC: begin
                state_nxt = FETCH;
                case (opcode)
                    OP_JMP:  addr_nxt = instr_r[N-1:0];
                    OP_SKZ:  addr_nxt = bus.zed ? addr_plus2 : addr_plus1;
                    OP_HLT:  state_nxt = HALT;
                    default: addr_nxt = addr_plus1;
                endcase
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            instr_r <= 8'h00;
        end else begin
            if (state == FETCH) begin
                instr_r <= bus.instruction;
            end
            addr_q <= addr_nxt;
        end
    end

    // The strobe is masked while rst is high so the control unit never sees it on a reset edge.
    assign bus.exec_en = (state == EXEC) && !is_ctrl && !rst;
    assign bus.addr    = addr_q;
    assign bus.instr_q = instr_r;
    assign bus.halted  = (state == HALT);
    assign bus.busy    = (state == FETCH) || (state == EXEC);

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Fetch/execute sequencer for the microprocessor core. It replaces the free-running program counter and drives the ROM address. It latches each fetched instruction and issues a one-cycle execute strobe to the control unit. It also resolves the three flow-control opcodes (jump, skip-if-zero, halt) in hardware, so the ICU and selectors only ever see data-path instructions.

## Interface

- N, default 2: ROM address width; legal range 1..4, because the jump target comes from instruction[3:0].

- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- run  input  1  level enable; high lets the sequencer fetch and execute, low pauses at the next FETCH
- instruction  input  8  ROM data for the current addr; combinational from ROM
- zed  input  1  zero flag from the data path; sampled only in EXEC
- addr  output  N  ROM address (program counter)
- instr_q  output  8  instruction register; holds the instruction being executed
- exec_en  output  1  one-cycle strobe; high only in EXEC for a data-path opcode
- halted  output  1  high while in HALT
- busy  output  1  high in FETCH or EXEC

## Operation

- States: IDLE, FETCH, EXEC, HALT. Reset forces IDLE.
- Control opcodes are decoded from instr_q[7:4]:
  - 4'hF JMP: next addr = instr_q[N-1:0]
  - 4'hE SKZ: next addr = addr+2 if zed=1, else addr+1
  - 4'hD HLT: enter HALT; addr is held
  - any other value is a data-path opcode: next addr = addr+1
- IDLE: if run=1, go to FETCH; otherwise stay. addr is held.
- FETCH: instr_q <= instruction (ROM output for the current addr). Then:
  - if run=1, go to EXEC
  - if run=0, go to IDLE; instr_q is still loaded, addr is unchanged
- EXEC:
  - exec_en=1 only when the opcode is not D/E/F
  - addr updates per the opcode rule at the end of the cycle
  - next state is FETCH, or HALT for HLT
  - run is ignored in EXEC; an EXEC always completes
- HALT: absorbing state. Only rst exits it, to IDLE. run and zed are ignored.
- Arithmetic: addr is modulo 2^N.
  - addr+1 at 2^N-1 wraps to 0.
  - SKZ taken at 2^N-2 gives 0; at 2^N-1 it gives 1.
- JMP to the current addr is legal and loops forever, with no exec_en pulses.
- zed is only meaningful in the EXEC cycle of an SKZ; it is ignored in all other states.

## Timing

- Reset values: addr=0, instr_q=8'h00, exec_en=0, halted=0, busy=0, state IDLE.
- rst=1 overrides everything on that edge, including mid-EXEC and in HALT. No exec_en is issued on or after the reset edge.
- Each instruction takes 2 cycles, FETCH then EXEC.
  - run rises at cycle 0 (sampled in IDLE): FETCH at cycle 1, EXEC at cycle 2, new addr visible at cycle 3.
- exec_en is exactly one cycle wide. instr_q is stable for the entire EXEC cycle and stays stable until the next FETCH.
- Outputs are registered or decoded from state only. No combinational path from instruction, zed or run to any output.
- halted asserts in the cycle after the HLT EXEC and stays high until rst.
- Pause and resume:
  - run falling in FETCH: the instruction is re-fetched from the same addr after resume.
  - run falling in EXEC: that EXEC completes, then FETCH proceeds, then IDLE.

## Test plan

- Reset/idle: assert rst for 2 cycles with run=0, then release. Hold 5 cycles: addr=0, instr_q=00, exec_en=0, busy=0, halted=0 throughout.
- Linear wrap, N=2, ROM={11,22,33,44}, run=1: exec_en pulses every 2nd cycle with instr_q = 11,22,33,44,11. addr sequence 0,1,2,3,0.
- SKZ, ROM={E0,55,66,D0}:
  - zed=1 at the EXEC of E0: next addr=2, instr_q 66 is executed, 55 is never seen.
  - Repeat with zed=0: 55 is executed.
  - exec_en stays 0 during the E0 EXEC.
- JMP and HALT, ROM={F2,77,D0,99}: addr goes 0 -> 2. halted=1 two cycles after the D0 FETCH. addr stays 2 for 20 cycles with no exec_en. Toggling run has no effect. rst returns addr=0, halted=0.
- Pause: drop run during the FETCH of addr=1. The next state is IDLE with addr=1. Raise run 4 cycles later: FETCH addr=1, then EXEC of ROM[1], with exactly one exec_en.
- Reset mid-EXEC: assert rst during the EXEC of 11 at addr=0. No exec_en on the following edge; addr=0 and state is IDLE.
